// File: rtl/display_radix_driver.sv
// -----------------------------------------------------------------------------
// display_radix_driver
//
// Converts an unsigned operand into NDIG active-low 7-segment glyphs in octal,
// decimal or hexadecimal, or blanks the display. A conversion always takes
// WIDTH SHIFT cycles plus one DONE cycle, whatever the radix.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (display blank, FSM idle)
//   start     single-cycle request, honoured only in IDLE
//   value     unsigned operand, latched on an accepted start
//   mode      00 octal, 01 decimal, 10 hex, 11 blank; latched with value
//   busy      high while the FSM is in SHIFT
//   done      one-cycle pulse in the cycle seg/overflow carry the new result
//   overflow  result needs more than NDIG digits (every digit shows a dash)
//   seg       digit k at [7k+6:7k], k=0 least significant; bit0=a ... bit6=g,
//             0 = segment lit
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                          significant nonzero digit are blanked (digit 0
//                          always shows). Dashes and mode-11 blanking are
//                          not affected.
// -----------------------------------------------------------------------------
module display_radix_driver #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7*NDIG-1:0] seg
);

    // Six digit positions cover every radix for operands up to 16 bits
    // (octal needs six, decimal five, hex four).
    localparam int MAXD = 6;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] M_OCT = 2'b00;
    localparam logic [1:0] M_DEC = 2'b01;
    localparam logic [1:0] M_HEX = 2'b10;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    val_q, val_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [1:0]          mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*MAXD-1:0]   bcd_q, bcd_d;
    logic [7*NDIG-1:0]   seg_q, seg_d;
    logic                ovf_q, ovf_d;

    logic [4*MAXD-1:0]   bcd_adj;
    logic [4*MAXD-1:0]   bcd_shift;
    logic [4*MAXD-1:0]   val_ext;
    logic [3:0]          dig [MAXD];
    logic [7*NDIG-1:0]   seg_new;
    logic                ovf_new;
    logic                lead_blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic                seen_nz;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Shift-add-3 step: correct every nibble >= 5, then shift the next
    // operand bit (MSB first) into the BCD accumulator.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < MAXD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[4*MAXD-2:0], sh_q[WIDTH-1]};
    end

    // Digit selection and glyph formation. Only meaningful on the last SHIFT
    // cycle, where bcd_shift holds the completed BCD result.
    always_comb begin
        val_ext = (4*MAXD)'(val_q);
        for (int i = 0; i < MAXD; i++) begin
            case (mode_q)
                M_OCT:   dig[i] = {1'b0, val_ext[3*i +: 3]};
                M_DEC:   dig[i] = bcd_shift[4*i +: 4];
                M_HEX:   dig[i] = val_ext[4*i +: 4];
                default: dig[i] = 4'h0;
            endcase
        end

        // A carry out of the top BCD nibble would be a seventh decimal digit.
        ovf_new = (mode_q == M_DEC) && bcd_adj[4*MAXD-1];
        for (int i = NDIG; i < MAXD; i++) begin
            if (dig[i] != 4'h0) begin
                ovf_new = 1'b1;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
`endif
        seg_new    = '1;
        lead_blank = 1'b0;
        for (int k = NDIG-1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            seen_nz    = seen_nz | (dig[k] != 4'h0);
            lead_blank = !seen_nz && (k != 0);
`else
            lead_blank = 1'b0;
`endif
            if (mode_q == 2'b11) begin
                seg_new[7*k +: 7] = GLYPH_BLANK;
            end else if (ovf_new) begin
                seg_new[7*k +: 7] = GLYPH_DASH;
            end else if (lead_blank) begin
                seg_new[7*k +: 7] = GLYPH_BLANK;
            end else begin
                seg_new[7*k +: 7] = glyph(dig[k]);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    val_d   = value;
                    sh_d    = value;
                    mode_d  = mode;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_shift;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    // Display registers change only here, so an aborted
                    // conversion never leaves a partial update behind.
                    seg_d   = seg_new;
                    ovf_d   = ovf_new;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            sh_q    <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            seg_q   <= '1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sh_q    <= sh_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign seg      = seg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_display_radix_driver.sv
// -----------------------------------------------------------------------------
// tb_display_radix_driver
//
// Two instances (NDIG=3 and NDIG=2) share one stimulus stream. A timing model
// decides which starts are accepted and pushes the expected display into a
// queue; a negedge monitor pops on done and compares seg/overflow/latency, and
// checks busy, done and held display values every cycle.
// -----------------------------------------------------------------------------
module tb_display_radix_driver;

    localparam int WIDTH  = 8;
    localparam int NDIG_A = 3;
    localparam int NDIG_B = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    value = '0;
    logic [1:0]          mode  = '0;

    logic                busy_a, done_a, ovf_a;
    logic [7*NDIG_A-1:0] seg_a;
    logic                busy_b, done_b, ovf_b;
    logic [7*NDIG_B-1:0] seg_b;

    always #5 clk = ~clk;

    display_radix_driver #(.WIDTH(WIDTH), .NDIG(NDIG_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .mode(mode),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .seg(seg_a)
    );

    display_radix_driver #(.WIDTH(WIDTH), .NDIG(NDIG_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .mode(mode),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .seg(seg_b)
    );

    typedef struct {
        int                  due;
        int                  v;
        int                  m;
        logic [7*NDIG_A-1:0] seg_a;
        logic                ovf_a;
        logic [7*NDIG_B-1:0] seg_b;
        logic                ovf_b;
    } exp_t;

    exp_t exp_q[$];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int model_cnt = 0;   // cycles left before the DUT can accept another start

    logic [7*NDIG_A-1:0] cur_seg_a = '1;
    logic                cur_ovf_a = 1'b0;
    logic [7*NDIG_B-1:0] cur_seg_b = '1;
    logic                cur_ovf_b = 1'b0;
    logic [41:0]         tmp_seg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int radix_of(input int m);
        return (m == 0) ? 8 : (m == 1) ? 10 : 16;
    endfunction

    function automatic int limit_of(input int ndig, input int m);
        int p = 1;
        for (int k = 0; k < ndig; k++) p = p * radix_of(m);
        return p;
    endfunction

    function automatic logic model_ovf(input int ndig, input int v, input int m);
        return (m != 3) && (v >= limit_of(ndig, m));
    endfunction

    // Display as read off the rules: repeated division for digits, dashes on
    // overflow, blanks for mode 3.
    function automatic logic [41:0] model_seg(input int ndig, input int v, input int m);
        logic [41:0] s;
        int          p;
        int          r;
        s = '1;
        if (m == 3) return s;
        r = radix_of(m);
        if (model_ovf(ndig, v, m)) begin
            for (int k = 0; k < ndig; k++) s[7*k +: 7] = DASH;
            return s;
        end
        p = 1;
        for (int k = 0; k < ndig; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && v < p) s[7*k +: 7] = BLANK;
            else                s[7*k +: 7] = GLYPH[(v / p) % r];
`else
            s[7*k +: 7] = GLYPH[(v / p) % r];
`endif
            p = p * r;
        end
        return s;
    endfunction

    // Acceptance/timing model.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            model_cnt = 0;
            exp_q.delete();
        end else if (model_cnt == 0) begin
            if (start) begin
                e.due   = cyc + WIDTH;
                e.v     = int'(value);
                e.m     = int'(mode);
                tmp_seg = model_seg(NDIG_A, e.v, e.m);
                e.seg_a = tmp_seg[7*NDIG_A-1:0];
                e.ovf_a = model_ovf(NDIG_A, e.v, e.m);
                tmp_seg = model_seg(NDIG_B, e.v, e.m);
                e.seg_b = tmp_seg[7*NDIG_B-1:0];
                e.ovf_b = model_ovf(NDIG_B, e.v, e.m);
                exp_q.push_back(e);
                model_cnt = WIDTH + 1;
            end
        end else begin
            model_cnt--;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        exp_t e;
        logic exp_done;
        if (!rst_n) begin
            cur_seg_a = '1; cur_ovf_a = 1'b0;
            cur_seg_b = '1; cur_ovf_b = 1'b0;
            chk("rst_busy_a", busy_a, 0);
            chk("rst_done_a", done_a, 0);
            chk("rst_busy_b", busy_b, 0);
            chk("rst_done_b", done_b, 0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: no done for v=%0d mode=%0d, expected at cycle %0d",
                         exp_q[0].v, exp_q[0].m, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("busy_a", busy_a, model_cnt >= 2);
            chk("busy_b", busy_b, model_cnt >= 2);
            chk("done_a", done_a, exp_done);
            chk("done_b", done_b, exp_done);
            if (done_a && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("latency", cyc, e.due);
                cur_seg_a = e.seg_a; cur_ovf_a = e.ovf_a;
                cur_seg_b = e.seg_b; cur_ovf_b = e.ovf_b;
                $display("txn cyc=%0d v=%0d mode=%0d seg3=%b ovf3=%b seg2=%b ovf2=%b",
                         cyc, e.v, e.m, seg_a, ovf_a, seg_b, ovf_b);
            end
        end
        chk("seg_a", seg_a, cur_seg_a);
        chk("ovf_a", ovf_a, cur_ovf_a);
        chk("seg_b", seg_b, cur_seg_b);
        chk("ovf_b", ovf_b, cur_ovf_b);
    end

    // Issue one conversion once the model says the DUT is idle.
    task automatic conv(input int v, input int m);
        int guard = 0;
        while (model_cnt != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        value = WIDTH'(v);
        mode  = 2'(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs wander during SHIFT; only the latched copies may matter.
        value = WIDTH'($urandom);
        mode  = 2'($urandom);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("async_busy_a", busy_a, 0);
        chk("async_seg_a", seg_a, {7*NDIG_A{1'b1}});
        chk("async_ovf_a", ovf_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        conv(255, 1);
        conv(255, 0);
        conv(255, 2);
        conv(255, 3);
        conv(100, 1);
        conv(171, 2);
        conv(7,   1);
        conv(42,  3);
        conv(0,   1);
        conv(63,  0);
        conv(64,  0);
        conv(99,  1);
        conv(16,  2);

        // Second start mid-conversion is ignored; reset aborts silently.
        conv(255, 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_pulse();
        conv(200, 1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(3) == 0);
            value = WIDTH'($urandom);
            mode  = 2'($urandom);
            if ($urandom_range(79) == 0) reset_pulse();
        end
        start = 1'b0;

        repeat (WIDTH + 4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
